// File: rtl/serial_comma_aligner.sv
// Receive-side K28.5 comma aligner: shifts in one line bit per fastClk edge,
// locks the 10-bit word boundary to comma position and emits aligned words.
module serial_comma_aligner #(
  parameter logic [9:0] COMMA_P      = 10'b0011111010,
  parameter logic [9:0] COMMA_N      = 10'b1100000101,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 3,
  parameter int         VERIFY_WORDS = 16
) (
  input  logic       fastClk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_bit,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       comma_det,
  output logic [7:0] realign_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);
  localparam logic [7:0] VERIFY_N = 8'(VERIFY_WORDS);

  logic [9:0] sr_q, sr_d, data_q, data_d;
  logic [3:0] cnt_q, cnt_d, good_q, good_d, bad_q, bad_d;
  logic [7:0] wcnt_q, wcnt_d, realign_q, realign_d;
  logic [1:0] state_q, state_d;
  logic       valid_q, locked_q, comma_q;
  logic       match_s, boundary_s, acquire_s, emit_s;

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign locked        = locked_q;
  assign comma_det     = comma_q;
  assign realign_count = realign_q;

  // Next-state: comma search, boundary tracking and lock FSM
  always_comb begin
    sr_d       = {sr_q[8:0], rx_bit};
    match_s    = (sr_d == COMMA_P) || (sr_d == COMMA_N);
    boundary_s = (cnt_q == 4'd9);
    cnt_d      = boundary_s ? 4'd0 : cnt_q + 4'd1;
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    wcnt_d     = wcnt_q;
    realign_d  = realign_q;
    acquire_s  = 1'b0;
    emit_s     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (match_s) begin
          acquire_s = 1'b1;
          if (LOCK_N == 4'd1) begin
            state_d = ST_LOCKED;
            emit_s  = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (match_s && boundary_s) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == LOCK_N) begin
            state_d = ST_LOCKED;
            emit_s  = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end else if (match_s) begin
          acquire_s = 1'b1;
        end else if (boundary_s) begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q + 8'd1 == VERIFY_N) begin
            state_d = ST_HUNT;
          end else begin
            state_d = ST_VERIFY;
          end
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (match_s && boundary_s) begin
          bad_d  = 4'd0;
          emit_s = 1'b1;
        end else if (match_s) begin
          // The word that knocks us out of lock is deliberately not emitted
          bad_d = bad_q + 4'd1;
          if (bad_q + 4'd1 == UNLOCK_N) begin
            acquire_s = 1'b1;
            state_d   = ST_VERIFY;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (boundary_s) begin
          emit_s = 1'b1;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (acquire_s) begin
      cnt_d     = 4'd0;
      good_d    = 4'd1;
      bad_d     = 4'd0;
      wcnt_d    = 8'd0;
      realign_d = (realign_q == 8'hFF) ? realign_q : realign_q + 8'd1;
    end else begin
      realign_d = realign_q;
    end

    data_d = emit_s ? sr_d : data_q;
  end

  // State registers; a low enable freezes everything but forces data_valid low
  always_ff @(posedge fastClk or posedge reset) begin
    if (reset) begin
      sr_q      <= 10'd0;
      cnt_q     <= 4'd0;
      state_q   <= ST_HUNT;
      good_q    <= 4'd0;
      bad_q     <= 4'd0;
      wcnt_q    <= 8'd0;
      realign_q <= 8'd0;
      data_q    <= 10'd0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      comma_q   <= 1'b0;
    end else if (enable) begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      wcnt_q    <= wcnt_d;
      realign_q <= realign_d;
      data_q    <= data_d;
      valid_q   <= emit_s;
      locked_q  <= (state_d == ST_LOCKED);
      comma_q   <= match_s;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_comma_aligner.sv
// Directed bench for serial_comma_aligner: lock, disparity mix, bit slip,
// verify timeout, enable stall and asynchronous reset.
module tb_serial_comma_aligner;

  localparam logic [9:0] CP = 10'h0FA;
  localparam logic [9:0] CN = 10'h305;
  localparam logic [9:0] DW = 10'h155;

  logic       fastClk = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b1;
  logic       rx_bit  = 1'b0;
  logic [9:0] data_out;
  logic       data_valid, locked, comma_det;
  logic [7:0] realign_count;

  int n_vec = 0;
  int n_err = 0;
  int v_seen = 0;
  int c_seen = 0;

  serial_comma_aligner dut (
    .fastClk(fastClk), .reset(reset), .enable(enable), .rx_bit(rx_bit),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .comma_det(comma_det), .realign_count(realign_count)
  );

  always #5 fastClk = ~fastClk;

  task automatic send_bit(input logic b);
    rx_bit = b;
    @(posedge fastClk);
    #1;
    v_seen += int'(data_valid);
    c_seen += int'(comma_det);
  endtask

  task automatic send_word(input logic [9:0] w, input int nbits);
    for (int i = 9; i > 9 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge fastClk);
    #1;
    reset = 1'b0;
    v_seen = 0;
    c_seen = 0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({data_out, data_valid, locked, comma_det, realign_count} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h/%b/%b/%b/%0d want all zero",
               data_out, data_valid, locked, comma_det, realign_count);
    end
    @(posedge fastClk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_lock_from_offset();
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_word(CP, 10);
    n_vec++;
    if (realign_count !== 8'd1 || comma_det !== 1'b1) begin
      n_err++;
      $display("FAIL offset_acquire: realign=%0d comma=%b want 1/1", realign_count, comma_det);
    end
    for (int k = 0; k < 3; k++) send_word(DW, 10);
    send_word(CP, 10);
    send_word(DW, 10);
    send_word(CP, 10);
    n_vec++;
    if (locked !== 1'b0 || v_seen != 0) begin
      n_err++;
      $display("FAIL offset_prelock: locked=%b valids=%0d want 0/0", locked, v_seen);
    end
    send_word(DW, 10);
    send_word(CP, 10);
    n_vec++;
    if (locked !== 1'b1 || data_valid !== 1'b1 || data_out !== CP) begin
      n_err++;
      $display("FAIL offset_lock: locked=%b valid=%b data=%h want 1/1/0fa", locked, data_valid, data_out);
    end
    for (int k = 0; k < 4; k++) begin
      v_seen = 0;
      send_word((k % 2 == 0) ? DW : CP, 10);
      n_vec++;
      if (v_seen != 1 || data_valid !== 1'b1 || data_out !== ((k % 2 == 0) ? DW : CP)) begin
        n_err++;
        $display("FAIL offset_stream: word %0d valids=%0d valid=%b data=%h", k, v_seen, data_valid, data_out);
      end
    end
    n_vec++;
    if (realign_count !== 8'd1) begin
      n_err++;
      $display("FAIL offset_realign: got %0d want 1", realign_count);
    end
  endtask

  task automatic test_disparity_mix();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      c_seen = 0;
      send_word((k % 2 == 0) ? CP : CN, 10);
      n_vec++;
      if (c_seen != 1 || comma_det !== 1'b1 || locked !== (k == 3)) begin
        n_err++;
        $display("FAIL disparity_word%0d: commas=%0d det=%b locked=%b", k, c_seen, comma_det, locked);
      end
    end
    n_vec++;
    if (data_out !== CN || data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL disparity_data: data=%h valid=%b want 305/1", data_out, data_valid);
    end
  endtask

  task automatic test_bit_slip();
    send_word(CP, 10);
    n_vec++;
    if (locked !== 1'b1 || data_out !== CP || data_valid !== 1'b1) begin
      n_err++;
      $display("FAIL slip_prelock: locked=%b data=%h valid=%b", locked, data_out, data_valid);
    end
    send_word(CP, 9);
    for (int k = 0; k < 3; k++) begin
      send_word(CP, 10);
      n_vec++;
      if (locked !== (k < 2)) begin
        n_err++;
        $display("FAIL slip_misaligned%0d: locked=%b want %b", k + 1, locked, (k < 2));
      end
    end
    n_vec++;
    if (realign_count !== 8'd2) begin
      n_err++;
      $display("FAIL slip_realign: got %0d want 2", realign_count);
    end
    v_seen = 0;
    for (int k = 0; k < 3; k++) begin
      send_word(CP, 10);
      n_vec++;
      if (locked !== (k == 2)) begin
        n_err++;
        $display("FAIL slip_relock%0d: locked=%b want %b", k, locked, (k == 2));
      end
    end
    n_vec++;
    if (v_seen != 1 || data_out !== CP) begin
      n_err++;
      $display("FAIL slip_relock_data: valids=%0d data=%h want 1/0fa", v_seen, data_out);
    end
  endtask

  task automatic test_verify_timeout();
    do_reset();
    send_word(CP, 10);
    for (int k = 0; k < 16; k++) send_word(DW, 10);
    n_vec++;
    if (locked !== 1'b0 || v_seen != 0 || realign_count !== 8'd1) begin
      n_err++;
      $display("FAIL timeout_quiet: locked=%b valids=%0d realign=%0d", locked, v_seen, realign_count);
    end
    send_word(CP, 10);
    n_vec++;
    if (realign_count !== 8'd2 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_hunt: realign=%0d locked=%b want 2/0", realign_count, locked);
    end
  endtask

  task automatic test_enable_stall();
    do_reset();
    for (int k = 0; k < 7; k++) send_word((k % 2 == 0) ? CP : DW, 10);
    n_vec++;
    if (locked !== 1'b1 || data_out !== CP) begin
      n_err++;
      $display("FAIL stall_lock: locked=%b data=%h", locked, data_out);
    end
    v_seen = 0;
    send_word(DW, 5);
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      send_bit(k[0]);
      n_vec++;
      if (data_valid !== 1'b0 || locked !== 1'b1) begin
        n_err++;
        $display("FAIL stall_cycle%0d: valid=%b locked=%b want 0/1", k, data_valid, locked);
      end
    end
    enable = 1'b1;
    for (int i = 4; i >= 0; i--) send_bit(DW[i]);
    n_vec++;
    if (v_seen != 1 || data_valid !== 1'b1 || data_out !== DW || locked !== 1'b1) begin
      n_err++;
      $display("FAIL stall_resume: valids=%0d valid=%b data=%h locked=%b", v_seen, data_valid, data_out, locked);
    end
  endtask

  task automatic test_reset_mid_lock();
    send_word(CP, 3);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({data_out, data_valid, locked, comma_det, realign_count} !== 21'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%b/%b/%b/%0d want all zero",
               data_out, data_valid, locked, comma_det, realign_count);
    end
    @(posedge fastClk);
    #1;
    reset = 1'b0;
    send_word(CP, 10);
    n_vec++;
    if (realign_count !== 8'd1 || comma_det !== 1'b1 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_hunt: realign=%0d det=%b locked=%b", realign_count, comma_det, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock_from_offset();
    test_disparity_mix();
    test_bit_slip();
    test_verify_timeout();
    test_enable_stall();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
